lc2k_decode_stage: RTL and testbench
====================================

Name: lc2k_decode_stage

Overview:
- LC2K pipeline ID stage: consumes fetched instruction words, reads an 8-entry register file, detects load-use hazards, and registers the ID/EX payload.
- The payload feeds the execute ALU: aluValA, aluValB and the 2-bit CONTROL_OPERATION (00 ADD, 01 NOR, 10 EQUAL).
- Owns the architectural register file; the WB stage writes it through this block.
- Honours branch flushes driven from EX.

Parameters:
- PC_WIDTH, 16, width of PC / pcPlus1 fields
- NUM_REGS, 8, register file depth (LC2K fixed; address width 3)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- inValid  in  1  IF has an instruction
- inReady  out  1  this stage accepts the instruction this cycle
- inInstr  in  32  LC2K instruction word
- inPcPlus1  in  PC_WIDTH  PC+1 of inInstr
- flush  in  1  branch taken in EX; squash ID and ID/EX contents
- wbEnable  in  1  register write from WB
- wbReg  in  3  write address
- wbData  in  32  write data
- outValid  out  1  ID/EX payload valid
- outReady  in  1  EX accepts payload
- aluValA  out  32  ALU operand A
- aluValB  out  32  ALU operand B
- CONTROL_OPERATION  out  2  ALU op select
- storeData  out  32  regB value, sw only
- destReg  out  3  writeback register
- regWrite  out  1  instruction writes a register
- memRead  out  1  lw
- memWrite  out  1  sw
- isBranch  out  1  beq
- isJalr  out  1  jalr
- isHalt  out  1  halt
- outPcPlus1  out  PC_WIDTH  forwarded PC+1
- offset  out  32  sign-extended offsetField

Behaviour:
- Decode fields: opcode = inInstr[24:22], regA = [21:19], regB = [18:16], R-type dest = [2:0], offset = sign-extended [15:0].
- Operations by opcode:
  - add (000): A = rA, B = rB, op 00, dest = [2:0], regWrite = 1.
  - nor (001): same as add, op 01.
  - lw (010): A = rA, B = offset, op 00, dest = regB, regWrite = 1, memRead = 1.
  - sw (011): A = rA, B = offset, op 00, storeData = rB, memWrite = 1.
  - beq (100): A = rA, B = rB, op 10, isBranch = 1.
  - jalr (101): A = rA, B = 0, op 00, dest = regB, regWrite = 1, isJalr = 1.
  - halt (110): op 00, isHalt = 1.
  - noop (111): op 00, no side effects.
- Register file:
  - 8 × 32. Writes to r0 are ignored; r0 always reads 0.
  - Write on clk edge when wbEnable.
  - Same-cycle write/read of the same nonzero register returns wbData (internal bypass).
- Handshake:
  - A transfer occurs when inValid && inReady.
  - The output register loads when the output is empty or being consumed (!outValid || outReady).
  - outValid holds, and every payload field stays stable, while outReady = 0.
- Load-use hazard:
  - Condition: outValid && memRead && destReg != 0 && destReg matches a register the ID instruction reads. Reads: rA for add/nor/lw/sw/beq/jalr; rB for add/nor/sw/beq.
  - On hazard, inReady = 0 and a bubble is inserted (outValid = 0 after EX consumes the lw).
  - Bubble lasts exactly one cycle; the instruction then issues with the value supplied through WB.
- Flush:
  - Highest priority. In the flush cycle, inReady = 1 and the input is discarded.
  - outValid clears on the next edge. Hazard and halt logic are ignored that cycle.
- State machine:
  - RUN: normal operation.
  - RUN → HALTED when a halt transfers to the output register (not flushed).
  - HALTED: inReady = 0 permanently; the output drains normally. Only rst_n exits.
  - A flush arriving while HALTED does not return to RUN.
- Reset (asynchronous, any time, including mid-stall):
  - State = RUN, outValid = 0, inReady = 0 while asserted.
  - All payload outputs = 0; all registers r0–r7 = 0.
- Latency: one cycle from accepted instruction to outValid.

Optional Feature:
- Macro: LC2K_STALL_COUNT_EN.
- With the macro:
  - Extra port stallCount, out, 32: counts cycles with hazard-induced inReady = 0.
  - Reset to 0; wraps at 2^32 − 1 → 0; not incremented during flush or HALTED.
- Without the macro: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset, then WB writes r1 = 5, r2 = 7; issue add 1,2,3 → next cycle outValid = 1, aluValA = 5, aluValB = 7, CONTROL_OPERATION = 00, destReg = 3, regWrite = 1.
- lw 0,4,offset −2 followed by nor 4,4,5 → one bubble cycle (outValid = 0, inReady = 0), then the nor issues; stallCount = 1 when LC2K_STALL_COUNT_EN.
- beq with r1 = r2 = 9, then assert flush while the next instruction is presented → that instruction is discarded; outValid = 0 next cycle.
- WB writes r0 = 0xFFFF; add 0,0,1 → aluValA = 0, aluValB = 0. Same-cycle WB write r3 = 42 with add 3,0,1 → aluValA = 42.
- Issue halt while outReady = 0 for 3 cycles → payload stable with isHalt = 1; after acceptance, inReady stays 0 indefinitely; a mid-run rst_n pulse returns to RUN with outValid = 0.

Source files
------------

// File: rtl/lc2k_decode_stage_if.sv
// lc2k_decode_stage_if: IF->ID instruction handshake plus the registered ID/EX payload bundle.
interface lc2k_decode_stage_if #(parameter int PC_WIDTH = 16);
  logic inValid, inReady;
  logic [31:0] inInstr;
  logic [PC_WIDTH-1:0] inPcPlus1;
  logic outValid, outReady;
  logic [31:0] aluValA, aluValB, storeData, offset;
  logic [1:0] CONTROL_OPERATION;
  logic [2:0] destReg;
  logic regWrite, memRead, memWrite, isBranch, isJalr, isHalt;
  logic [PC_WIDTH-1:0] outPcPlus1;
  modport master (
    output inValid, inInstr, inPcPlus1, outReady,
    input  inReady, outValid, aluValA, aluValB, CONTROL_OPERATION, storeData, destReg,
           regWrite, memRead, memWrite, isBranch, isJalr, isHalt, outPcPlus1, offset
  );
  modport slave (
    input  inValid, inInstr, inPcPlus1, outReady,
    output inReady, outValid, aluValA, aluValB, CONTROL_OPERATION, storeData, destReg,
           regWrite, memRead, memWrite, isBranch, isJalr, isHalt, outPcPlus1, offset
  );
endinterface

// File: rtl/lc2k_decode_stage.sv
// lc2k_decode_stage: LC2K ID stage with register file, load-use stall and ID/EX register.
// Optional LC2K_STALL_COUNT_EN adds a stallCount port counting hazard stall cycles.
module lc2k_decode_stage #(
  parameter int PC_WIDTH = 16,
  parameter int NUM_REGS = 8
) (
  input  logic clk,
  input  logic rst_n,
  lc2k_decode_stage_if.slave io,
  input  logic flush,
  input  logic wbEnable,
  input  logic [2:0] wbReg,
  input  logic [31:0] wbData
`ifdef LC2K_STALL_COUNT_EN
  , output logic [31:0] stallCount
`endif
);
  typedef enum logic {RUN, HALTED} stateT;
  stateT state;
  logic [31:0] rf [NUM_REGS];
  logic [2:0] opc, rA, rB;
  logic [31:0] valA, valB, sext;
  logic usesA, usesB, isMem, hazard, canLoad, fire, unusedHi;
  assign opc = io.inInstr[24:22];
  assign rA = io.inInstr[21:19];
  assign rB = io.inInstr[18:16];
  assign sext = {{16{io.inInstr[15]}}, io.inInstr[15:0]};
  assign unusedHi = ^io.inInstr[31:25];
  assign isMem = opc == 3'b010 || opc == 3'b011;
  // WB bypass lets a same-cycle write reach the reader; r0 is hardwired
  assign valA = rA == 3'd0 ? 32'd0 : (wbEnable && wbReg == rA) ? wbData : rf[rA];
  assign valB = rB == 3'd0 ? 32'd0 : (wbEnable && wbReg == rB) ? wbData : rf[rB];
  assign usesA = opc <= 3'b101;
  assign usesB = opc[2:1] == 2'b00 || opc == 3'b011 || opc == 3'b100;
  assign hazard = io.inValid && io.outValid && io.memRead && io.destReg != 3'd0 &&
                  ((usesA && io.destReg == rA) || (usesB && io.destReg == rB));
  assign canLoad = !io.outValid || io.outReady;
  assign io.inReady = rst_n && state == RUN && (flush || (canLoad && !hazard));
  assign fire = io.inValid && io.inReady && !flush;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wbEnable && wbReg != 3'd0) begin
      rf[wbReg] <= wbData;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      io.outValid <= 1'b0;
      io.aluValA <= '0;
      io.aluValB <= '0;
      io.CONTROL_OPERATION <= '0;
      io.storeData <= '0;
      io.destReg <= '0;
      io.regWrite <= 1'b0;
      io.memRead <= 1'b0;
      io.memWrite <= 1'b0;
      io.isBranch <= 1'b0;
      io.isJalr <= 1'b0;
      io.isHalt <= 1'b0;
      io.outPcPlus1 <= '0;
      io.offset <= '0;
    end else begin
      if (flush) io.outValid <= 1'b0;
      else if (canLoad) io.outValid <= fire;
      if (fire) begin
        if (opc == 3'b110) state <= HALTED;
        io.aluValA <= opc[2:1] == 2'b11 ? 32'd0 : valA;
        io.aluValB <= isMem ? sext : (opc == 3'b101 || opc[2:1] == 2'b11) ? 32'd0 : valB;
        io.CONTROL_OPERATION <= opc == 3'b001 ? 2'b01 : opc == 3'b100 ? 2'b10 : 2'b00;
        io.storeData <= opc == 3'b011 ? valB : 32'd0;
        io.destReg <= opc[2:1] == 2'b00 ? io.inInstr[2:0] : (opc == 3'b010 || opc == 3'b101) ? rB : 3'd0;
        io.regWrite <= opc[2:1] == 2'b00 || opc == 3'b010 || opc == 3'b101;
        io.memRead <= opc == 3'b010;
        io.memWrite <= opc == 3'b011;
        io.isBranch <= opc == 3'b100;
        io.isJalr <= opc == 3'b101;
        io.isHalt <= opc == 3'b110;
        io.outPcPlus1 <= PC_WIDTH'(io.inPcPlus1);
        io.offset <= sext;
      end
    end
  end
`ifdef LC2K_STALL_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stallCount <= '0;
    else if (hazard && state == RUN && !flush) stallCount <= stallCount + 32'd1;
  end
`endif
endmodule

// File: tb/tb_lc2k_decode_stage.sv
// tb_lc2k_decode_stage: directed checks of decode, hazard bubble, flush, r0/bypass and halt.
module tb_lc2k_decode_stage;
  logic clk, rst_n, flush, wbEnable;
  logic [2:0] wbReg;
  logic [31:0] wbData;
  int total = 0, bad = 0;
`ifdef LC2K_STALL_COUNT_EN
  logic [31:0] stallCount;
`endif
  lc2k_decode_stage_if #(.PC_WIDTH(16)) bus ();
  lc2k_decode_stage #(.PC_WIDTH(16), .NUM_REGS(8)) dut (
    .clk(clk), .rst_n(rst_n), .io(bus), .flush(flush),
    .wbEnable(wbEnable), .wbReg(wbReg), .wbData(wbData)
`ifdef LC2K_STALL_COUNT_EN
    , .stallCount(stallCount)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] mk(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b, input logic [15:0] f);
    return {7'd0, op, a, b, f};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; flush = 1'b0; wbEnable = 1'b0; wbReg = '0; wbData = '0;
    bus.inValid = 1'b1; bus.inInstr = mk(3'b000, 3'd1, 3'd2, 16'd3); bus.inPcPlus1 = 16'd10; bus.outReady = 1'b1;
    #1;
    chk("rst_outValid", bus.outValid, 0);
    chk("rst_inReady", bus.inReady, 0);
    chk("rst_aluValA", bus.aluValA, 0);
    chk("rst_destReg", bus.destReg, 0);
    tick(); tick();
    rst_n = 1'b1; bus.inValid = 1'b0;
    wbEnable = 1'b1; wbReg = 3'd1; wbData = 32'd5;
    tick();
    wbReg = 3'd2; wbData = 32'd7;
    tick();
    wbEnable = 1'b0; bus.inValid = 1'b1;
    #1;
    chk("add_inReady", bus.inReady, 1);
    tick();
    chk("add_outValid", bus.outValid, 1);
    chk("add_A", bus.aluValA, 5);
    chk("add_B", bus.aluValB, 7);
    chk("add_op", bus.CONTROL_OPERATION, 0);
    chk("add_dest", bus.destReg, 3);
    chk("add_regWrite", bus.regWrite, 1);
    chk("add_pc", bus.outPcPlus1, 10);
    bus.inInstr = mk(3'b010, 3'd0, 3'd4, 16'hFFFE); bus.inPcPlus1 = 16'd11;
    tick();
    chk("lw_outValid", bus.outValid, 1);
    chk("lw_memRead", bus.memRead, 1);
    chk("lw_B", bus.aluValB, 32'hFFFF_FFFE);
    chk("lw_dest", bus.destReg, 4);
    bus.inInstr = mk(3'b001, 3'd4, 3'd4, 16'd5); bus.inPcPlus1 = 16'd12;
    #1;
    chk("hazard_inReady", bus.inReady, 0);
    tick();
    chk("bubble_outValid", bus.outValid, 0);
    wbEnable = 1'b1; wbReg = 3'd4; wbData = 32'h30;
    #1;
    chk("postbubble_inReady", bus.inReady, 1);
    tick();
    chk("nor_outValid", bus.outValid, 1);
    chk("nor_A", bus.aluValA, 32'h30);
    chk("nor_B", bus.aluValB, 32'h30);
    chk("nor_op", bus.CONTROL_OPERATION, 1);
    chk("nor_dest", bus.destReg, 5);
`ifdef LC2K_STALL_COUNT_EN
    chk("stallCount", stallCount, 1);
`endif
    bus.inValid = 1'b0; wbReg = 3'd1; wbData = 32'd9;
    tick();
    wbReg = 3'd2;
    tick();
    wbEnable = 1'b0; bus.inValid = 1'b1; bus.inInstr = mk(3'b100, 3'd1, 3'd2, 16'd5);
    tick();
    chk("beq_isBranch", bus.isBranch, 1);
    chk("beq_A", bus.aluValA, 9);
    chk("beq_B", bus.aluValB, 9);
    chk("beq_op", bus.CONTROL_OPERATION, 2);
    chk("beq_offset", bus.offset, 5);
    chk("beq_regWrite", bus.regWrite, 0);
    bus.inInstr = mk(3'b000, 3'd1, 3'd2, 16'd3); flush = 1'b1;
    #1;
    chk("flush_inReady", bus.inReady, 1);
    tick();
    chk("flush_outValid", bus.outValid, 0);
    flush = 1'b0;
    wbEnable = 1'b1; wbReg = 3'd0; wbData = 32'hFFFF; bus.inInstr = mk(3'b000, 3'd0, 3'd0, 16'd1);
    tick();
    chk("r0_A", bus.aluValA, 0);
    chk("r0_B", bus.aluValB, 0);
    wbReg = 3'd3; wbData = 32'd42; bus.inInstr = mk(3'b000, 3'd3, 3'd0, 16'd1);
    tick();
    chk("bypass_A", bus.aluValA, 42);
    chk("bypass_B", bus.aluValB, 0);
    wbEnable = 1'b0; bus.inValid = 1'b0;
    tick();
    bus.inValid = 1'b1; bus.inInstr = mk(3'b110, 3'd0, 3'd0, 16'd0); bus.outReady = 1'b0;
    tick();
    bus.inInstr = mk(3'b000, 3'd1, 3'd2, 16'd3);
    for (int i = 0; i < 3; i++) begin
      chk("halt_hold_valid", bus.outValid, 1);
      chk("halt_hold_isHalt", bus.isHalt, 1);
      chk("halt_hold_inReady", bus.inReady, 0);
      if (i < 2) tick();
    end
    bus.outReady = 1'b1;
    tick();
    chk("halt_drained", bus.outValid, 0);
    chk("halted_inReady", bus.inReady, 0);
    flush = 1'b1;
    #1;
    chk("halted_flush_inReady", bus.inReady, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("halted_after_flush", bus.inReady, 0);
    tick();
    chk("halted_still", bus.inReady, 0);
    chk("halted_no_issue", bus.outValid, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_outValid", bus.outValid, 0);
    chk("midrst_inReady", bus.inReady, 0);
    chk("midrst_isHalt", bus.isHalt, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rerun_inReady", bus.inReady, 1);
    tick();
    chk("rerun_outValid", bus.outValid, 1);
    chk("rerun_A_cleared", bus.aluValA, 0);
    chk("rerun_B_cleared", bus.aluValB, 0);
    chk("rerun_dest", bus.destReg, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
